// File: rtl/translate_control_pkg.sv
// Shared encodings for the MIPS-subset decoder: opcode/func constants and
// control-field encodings used by translate_control and its sub-module.
package translate_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [2:0] {
        AOP_ADD = 3'b000,
        AOP_SUB = 3'b001,
        AOP_AND = 3'b010,
        AOP_OR  = 3'b011,
        AOP_XOR = 3'b100,
        AOP_NOR = 3'b101,
        AOP_SLT = 3'b110
    } aop_t;

    typedef enum logic [1:0] {
        WRS_RD = 2'b00,
        WRS_RT = 2'b01,
        WRS_RA = 2'b10
    } wrs_t;

    typedef enum logic [1:0] {
        WRDS_ALU = 2'b00,
        WRDS_MEM = 2'b01,
        WRDS_PC4 = 2'b10,
        WRDS_LUI = 2'b11
    } wrds_t;

    typedef enum logic [1:0] {
        PCS_SEQ = 2'b00,
        PCS_BR  = 2'b01,
        PCS_JMP = 2'b10,
        PCS_JR  = 2'b11
    } pcs_t;

endpackage

// File: rtl/translate_control_alu_op_decode.sv
// R-type function-field decoder: ALU operation plus a bit saying whether the
// func value is one of the supported ALU instructions (jr is handled above).
module alu_op_decode
    import translate_control_pkg::*;
(
    input  logic [5:0] func,
    output aop_t       aop,
    output logic       valid
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; that is what keeps combinational logic free of latches.
    always_comb begin
        aop   = AOP_ADD;
        valid = 1'b1;
        case (func)
            FN_ADD, FN_ADDU: aop = AOP_ADD;
            FN_SUB, FN_SUBU: aop = AOP_SUB;
            FN_AND:          aop = AOP_AND;
            FN_OR:           aop = AOP_OR;
            FN_XOR:          aop = AOP_XOR;
            FN_NOR:          aop = AOP_NOR;
            FN_SLT:          aop = AOP_SLT;
            default:         valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/translate_control.sv
// Single-cycle MIPS-subset control unit: combinational decode of opa/func/zf
// into datapath controls, plus a sticky illegal-instruction flag.
module translate_control
    import translate_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opa,
    input  logic [5:0] func,
    input  logic       zf,
    output logic [1:0] wrs,
    output logic       imms,
    output logic       rims,
    output logic [1:0] wrds,
    output logic [2:0] aop,
    output logic       wea,
    output logic       mwa,
    output logic [1:0] pcs,
    output logic       ill
);

    aop_t  r_aop;
    logic  r_valid;
    wrs_t  wrs_d;
    wrds_t wrds_d;
    aop_t  aop_d;
    pcs_t  pcs_d;
    logic  imms_d, rims_d, wea_d, mwa_d, illegal;

    alu_op_decode u_alu_op_decode (
        .func  (func),
        .aop   (r_aop),
        .valid (r_valid)
    );

    always_comb begin
        wrs_d   = WRS_RD;
        imms_d  = 1'b0;
        rims_d  = 1'b0;
        wrds_d  = WRDS_ALU;
        aop_d   = AOP_ADD;
        wea_d   = 1'b0;
        mwa_d   = 1'b0;
        pcs_d   = PCS_SEQ;
        illegal = 1'b0;
        case (opa)
            OP_RTYPE: begin
                if (func == FN_JR) begin
                    pcs_d = PCS_JR;
                end else if (r_valid) begin
                    aop_d = r_aop;
                    wea_d = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                wrs_d  = WRS_RT;
                rims_d = 1'b1;
                wea_d  = 1'b1;
                case (opa)
                    OP_ADDI, OP_ADDIU: imms_d = 1'b1;
                    OP_SLTI: begin
                        imms_d = 1'b1;
                        aop_d  = AOP_SLT;
                    end
                    OP_ANDI: aop_d = AOP_AND;
                    OP_ORI:  aop_d = AOP_OR;
                    OP_XORI: aop_d = AOP_XOR;
                    OP_LUI:  wrds_d = WRDS_LUI;
                    OP_LW: begin
                        imms_d = 1'b1;
                        wrds_d = WRDS_MEM;
                    end
                    default: ;
                endcase
            end
            OP_SW: begin
                imms_d = 1'b1;
                rims_d = 1'b1;
                mwa_d  = 1'b1;
            end
            // Branches compare via subtract; zf of that result picks the target.
            OP_BEQ, OP_BNE: begin
                imms_d = 1'b1;
                aop_d  = AOP_SUB;
                if (zf == (opa == OP_BEQ))
                    pcs_d = PCS_BR;
            end
            OP_J: pcs_d = PCS_JMP;
            OP_JAL: begin
                pcs_d  = PCS_JMP;
                wrs_d  = WRS_RA;
                wrds_d = WRDS_PC4;
                wea_d  = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Reset only blocks architectural side effects; other fields keep decoding.
    assign wrs  = wrs_d;
    assign imms = imms_d;
    assign rims = rims_d;
    assign wrds = wrds_d;
    assign aop  = aop_d;
    assign wea  = wea_d & ~rst;
    assign mwa  = mwa_d & ~rst;
    assign pcs  = rst ? PCS_SEQ : pcs_d;

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ill <= 1'b0;
        else if (illegal)
            ill <= 1'b1;
    end

endmodule

// File: tb/tb_translate_control.sv
// Scoreboard bench for translate_control: directed vectors push hand-computed
// expectations; a monitor pops and compares one cycle later.
module tb_translate_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opa, func;
    logic       zf;
    logic [1:0] wrs, wrds, pcs;
    logic       imms, rims, wea, mwa, ill;
    logic [2:0] aop;

    int checks = 0;
    int errors = 0;
    int vec_id = 0;
    logic exp_ill = 1'b0;

    typedef struct {
        int         id;
        logic [1:0] wrs;
        logic       imms;
        logic       rims;
        logic [1:0] wrds;
        logic [2:0] aop;
        logic       wea;
        logic       mwa;
        logic [1:0] pcs;
        logic       ill;
    } exp_t;

    exp_t sb[$];

    translate_control dut (
        .clk  (clk),
        .rst  (rst),
        .opa  (opa),
        .func (func),
        .zf   (zf),
        .wrs  (wrs),
        .imms (imms),
        .rims (rims),
        .wrds (wrds),
        .aop  (aop),
        .wea  (wea),
        .mwa  (mwa),
        .pcs  (pcs),
        .ill  (ill)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0h, expected %0h", name, id, act, exp);
        end
    endtask

    // Apply one vector at the falling edge and queue its expected response.
    task automatic drive(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z,
                         input logic [1:0] e_wrs, input logic e_imms, input logic e_rims,
                         input logic [1:0] e_wrds, input logic [2:0] e_aop, input logic e_wea,
                         input logic e_mwa, input logic [1:0] e_pcs, input logic is_illegal);
        exp_t e;
        @(negedge clk);
        rst  = r;
        opa  = o;
        func = f;
        zf   = z;
        exp_ill = r ? 1'b0 : (exp_ill | is_illegal);
        e.id   = vec_id;
        e.wrs  = e_wrs;
        e.imms = e_imms;
        e.rims = e_rims;
        e.wrds = e_wrds;
        e.aop  = e_aop;
        e.wea  = e_wea;
        e.mwa  = e_mwa;
        e.pcs  = e_pcs;
        e.ill  = exp_ill;
        sb.push_back(e);
        vec_id++;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("wrs",  e.id, {6'd0, wrs},  {6'd0, e.wrs});
            check("imms", e.id, {7'd0, imms}, {7'd0, e.imms});
            check("rims", e.id, {7'd0, rims}, {7'd0, e.rims});
            check("wrds", e.id, {6'd0, wrds}, {6'd0, e.wrds});
            check("aop",  e.id, {5'd0, aop},  {5'd0, e.aop});
            check("wea",  e.id, {7'd0, wea},  {7'd0, e.wea});
            check("mwa",  e.id, {7'd0, mwa},  {7'd0, e.mwa});
            check("pcs",  e.id, {6'd0, pcs},  {6'd0, e.pcs});
            check("ill",  e.id, {7'd0, ill},  {7'd0, e.ill});
        end
    end

    initial begin
        rst = 1'b1; opa = 6'd0; func = 6'b100000; zf = 1'b0;
        //     rst  opa        func       zf   wrs    imms  rims  wrds   aop     wea   mwa   pcs    illegal
        drive(1'b1, 6'b000000, 6'b100000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0); // add in reset
        drive(1'b0, 6'b000000, 6'b100000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0); // add
        drive(1'b0, 6'b000000, 6'b100001, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0); // addu, zf ignored
        drive(1'b0, 6'b000000, 6'b100010, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b001, 1'b1, 1'b0, 2'b00, 1'b0); // sub
        drive(1'b0, 6'b000000, 6'b100011, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b001, 1'b1, 1'b0, 2'b00, 1'b0); // subu
        drive(1'b0, 6'b000000, 6'b100100, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b010, 1'b1, 1'b0, 2'b00, 1'b0); // and
        drive(1'b0, 6'b000000, 6'b100101, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b011, 1'b1, 1'b0, 2'b00, 1'b0); // or
        drive(1'b0, 6'b000000, 6'b100110, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b100, 1'b1, 1'b0, 2'b00, 1'b0); // xor
        drive(1'b0, 6'b000000, 6'b100111, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b101, 1'b1, 1'b0, 2'b00, 1'b0); // nor
        drive(1'b0, 6'b000000, 6'b101010, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b110, 1'b1, 1'b0, 2'b00, 1'b0); // slt
        drive(1'b0, 6'b000000, 6'b001000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 2'b11, 1'b0); // jr
        drive(1'b0, 6'b001000, 6'b000000, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0); // addi
        drive(1'b0, 6'b001001, 6'b111111, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0); // addiu
        drive(1'b0, 6'b001010, 6'b000000, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 3'b110, 1'b1, 1'b0, 2'b00, 1'b0); // slti
        drive(1'b0, 6'b001100, 6'b000000, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 3'b010, 1'b1, 1'b0, 2'b00, 1'b0); // andi
        drive(1'b0, 6'b001101, 6'b000000, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 3'b011, 1'b1, 1'b0, 2'b00, 1'b0); // ori
        drive(1'b0, 6'b001110, 6'b000000, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 3'b100, 1'b1, 1'b0, 2'b00, 1'b0); // xori
        drive(1'b0, 6'b001111, 6'b000000, 1'b0, 2'b01, 1'b0, 1'b1, 2'b11, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0); // lui
        drive(1'b0, 6'b100011, 6'b000000, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0); // lw
        drive(1'b0, 6'b101011, 6'b000000, 1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1'b1, 2'b00, 1'b0); // sw
        drive(1'b0, 6'b000100, 6'b000000, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 3'b001, 1'b0, 1'b0, 2'b01, 1'b0); // beq taken
        drive(1'b0, 6'b000100, 6'b000000, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 3'b001, 1'b0, 1'b0, 2'b00, 1'b0); // beq not taken
        drive(1'b0, 6'b000101, 6'b000000, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 3'b001, 1'b0, 1'b0, 2'b01, 1'b0); // bne taken
        drive(1'b0, 6'b000101, 6'b000000, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 3'b001, 1'b0, 1'b0, 2'b00, 1'b0); // bne not taken
        drive(1'b0, 6'b000010, 6'b000000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 2'b10, 1'b0); // j
        drive(1'b0, 6'b000011, 6'b000000, 1'b0, 2'b10, 1'b0, 1'b0, 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 1'b0); // jal
        drive(1'b1, 6'b000100, 6'b000000, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 3'b001, 1'b0, 1'b0, 2'b00, 1'b0); // beq in reset
        drive(1'b1, 6'b101011, 6'b000000, 1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0); // sw in reset
        drive(1'b0, 6'b111111, 6'b000000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1); // illegal opa
        drive(1'b0, 6'b000000, 6'b100000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0); // add, ill sticky
        drive(1'b0, 6'b001000, 6'b000000, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0); // addi, ill sticky

        // ill must clear as soon as rst rises, without waiting for a clock.
        @(negedge clk);
        rst = 1'b1;
        exp_ill = 1'b0;
        #1;
        check("ill_async_clear", vec_id, {7'd0, ill}, 8'd0);

        drive(1'b1, 6'b000000, 6'b100000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0); // add in reset
        drive(1'b1, 6'b111111, 6'b000000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1); // illegal in reset
        drive(1'b0, 6'b000000, 6'b100000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0); // add after release
        drive(1'b0, 6'b000000, 6'b000000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1); // bad func (sll)
        drive(1'b0, 6'b000100, 6'b000000, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 3'b001, 1'b0, 1'b0, 2'b01, 1'b0); // beq, ill sticky

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
